// File: rtl/outer_product_ctrl_if.sv
// Handshake bundle between a job source and the outer-product controller.
// stall_cnt is present only when OUTER_PRODUCT_CTRL_PERF_EN is defined.
interface outer_product_ctrl_if #(
    parameter int K_WIDTH = 8
);
    logic               start;
    logic [K_WIDTH-1:0] k_len;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic               pe_clear;
    logic               pe_enable;
    logic [K_WIDTH-1:0] k_idx;
    logic               busy;
    logic               done;
`ifdef OUTER_PRODUCT_CTRL_PERF_EN
    logic [15:0]        stall_cnt;

    modport master (
        output start, k_len, abort, in_valid,
        input  in_ready, pe_clear, pe_enable,
        input  k_idx, busy, done, stall_cnt
    );

    modport slave (
        input  start, k_len, abort, in_valid,
        output in_ready, pe_clear, pe_enable,
        output k_idx, busy, done, stall_cnt
    );
`else
    modport master (
        output start, k_len, abort, in_valid,
        input  in_ready, pe_clear, pe_enable,
        input  k_idx, busy, done
    );

    modport slave (
        input  start, k_len, abort, in_valid,
        output in_ready, pe_clear, pe_enable,
        output k_idx, busy, done
    );
`endif
endinterface

// File: rtl/outer_product_ctrl.sv
// Sequencer for an outer-product PE array: clear, accumulate k_len beats, drain, done.
// Define OUTER_PRODUCT_CTRL_PERF_EN to add the 16-bit stall_cnt counter.
module outer_product_ctrl #(
    parameter int K_WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    outer_product_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [K_WIDTH-1:0] klen_q;
    logic [K_WIDTH-1:0] klen_d;
    logic [K_WIDTH-1:0] kidx_q;
    logic [K_WIDTH-1:0] kidx_d;
    logic [K_WIDTH:0]   kidx_inc;
    logic               last_beat;
    logic               accept_start;

    // One extra bit so k_len = 2^K_WIDTH-1 compares without wrapping.
    assign kidx_inc  = {1'b0, kidx_q} + {{K_WIDTH{1'b0}}, 1'b1};
    assign last_beat = (kidx_inc == {1'b0, klen_q});

    assign accept_start = (state_q == S_IDLE) & bus.start & ~bus.abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            kidx_q  <= kidx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        klen_d        = klen_q;
        kidx_d        = kidx_q;
        bus.in_ready  = 1'b0;
        bus.pe_clear  = 1'b0;
        bus.pe_enable = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                kidx_d = '0;
                if (accept_start) begin
                    klen_d  = bus.k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.pe_clear = 1'b1;
                kidx_d       = '0;
                state_d      = (klen_q != '0) ? S_ACCUM : S_DRAIN;
            end
            S_ACCUM: begin
                bus.in_ready  = 1'b1;
                bus.pe_enable = bus.in_valid;
                if (bus.in_valid) begin
                    kidx_d = kidx_inc[K_WIDTH-1:0];
                    if (last_beat) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                kidx_d   = '0;
                state_d  = S_IDLE;
            end
            default: begin
                kidx_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        // Abort beats everything, including a same-cycle start.
        if (bus.abort) begin
            state_d = S_IDLE;
            kidx_d  = '0;
        end
    end

    assign bus.busy  = (state_q != S_IDLE);
    assign bus.k_idx = kidx_q;

`ifdef OUTER_PRODUCT_CTRL_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept_start) begin
            stall_q <= '0;
        end else if (state_q == S_ACCUM && !bus.in_valid
                     && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_outer_product_ctrl.sv
// Directed table-driven bench for outer_product_ctrl plus reset and
// maximum-length sequences.
module tb_outer_product_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    outer_product_ctrl_if #(.K_WIDTH(8)) bus ();

    outer_product_ctrl #(.K_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       start;
        logic [7:0] k;
        logic       abort;
        logic       iv;
        logic       rdy;
        logic       clr;
        logic       en;
        int         idx;
        logic       busy;
        logic       done;
        int         stall;
    } vec_t;

    vec_t tbl[$];
    int   ncmp = 0;
    int   nfail = 0;

    function automatic vec_t v(
        logic s, int k, logic a, logic iv,
        logic rdy, logic clr, logic en, int idx,
        logic busy, logic done, int stall
    );
        vec_t r;
        r.start = s;
        r.k     = k[7:0];
        r.abort = a;
        r.iv    = iv;
        r.rdy   = rdy;
        r.clr   = clr;
        r.en    = en;
        r.idx   = idx;
        r.busy  = busy;
        r.done  = done;
        r.stall = stall;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(string tag);
        chk({tag, " in_ready"}, int'(bus.in_ready), 0);
        chk({tag, " pe_enable"}, int'(bus.pe_enable), 0);
        chk({tag, " pe_clear"}, int'(bus.pe_clear), 0);
        chk({tag, " busy"}, int'(bus.busy), 0);
        chk({tag, " done"}, int'(bus.done), 0);
        chk({tag, " k_idx"}, int'(bus.k_idx), 0);
    endtask

    initial begin
        int enables;
        int last_idx;
        int done_at;

        bus.start    = 1'b0;
        bus.k_len    = '0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;

        // k_len=4, in_valid held high
        tbl.push_back(v(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, i, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, -1, 1, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, -1, 1, 1, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, -1));
        // k_len=3 with two stall cycles after the first beat
        tbl.push_back(v(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 2));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, 2, 1, 0, 2));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, -1, 1, 0, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, -1, 1, 1, 2));
        // k_len=0
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, -1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, -1, 1, 1, 0));
        // start during ACCUM ignored
        tbl.push_back(v(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, -1));
        tbl.push_back(v(1, 5, 0, 1, 1, 0, 1, 0, 1, 0, -1));
        tbl.push_back(v(1, 5, 0, 1, 1, 0, 1, 1, 1, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, -1, 1, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, -1, 1, 1, -1));
        // abort on the second beat, abort beats start, then k_len=2
        tbl.push_back(v(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, -1));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 1, 1, 1, 0, -1));
        tbl.push_back(v(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(v(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, 1, 1, 0, -1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, -1, 1, 0, -1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, -1, 1, 1, -1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));

        #1;
        chk_idle("reset");
`ifdef OUTER_PRODUCT_CTRL_PERF_EN
        chk("reset stall_cnt", int'(bus.stall_cnt), 0);
`endif
        #11 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus.start    = tbl[i].start;
            bus.k_len    = tbl[i].k;
            bus.abort    = tbl[i].abort;
            bus.in_valid = tbl[i].iv;
            #1;
            chk($sformatf("row%0d in_ready", i), int'(bus.in_ready), int'(tbl[i].rdy));
            chk($sformatf("row%0d pe_clear", i), int'(bus.pe_clear), int'(tbl[i].clr));
            chk($sformatf("row%0d pe_enable", i), int'(bus.pe_enable), int'(tbl[i].en));
            chk($sformatf("row%0d busy", i), int'(bus.busy), int'(tbl[i].busy));
            chk($sformatf("row%0d done", i), int'(bus.done), int'(tbl[i].done));
            if (tbl[i].idx >= 0)
                chk($sformatf("row%0d k_idx", i), int'(bus.k_idx), tbl[i].idx);
`ifdef OUTER_PRODUCT_CTRL_PERF_EN
            if (tbl[i].stall >= 0)
                chk($sformatf("row%0d stall_cnt", i), int'(bus.stall_cnt), tbl[i].stall);
`endif
        end

        // asynchronous reset in the middle of ACCUM
        @(negedge clk);
        bus.start = 1'b1; bus.k_len = 8'd4; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1 chk("pre-rst pe_enable", int'(bus.pe_enable), 1);
        #1 rst = 1'b1;
        #1 chk_idle("async rst");
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1; bus.k_len = 8'd1;
        #1 chk_idle("rst release");
        @(negedge clk);
        bus.start = 1'b0;
        #1 chk("post-rst pe_clear", int'(bus.pe_clear), 1);
        chk("post-rst busy", int'(bus.busy), 1);
        @(negedge clk);
        #1 chk("post-rst pe_enable", int'(bus.pe_enable), 1);
        @(negedge clk);
        @(negedge clk);
        #1 chk("post-rst done", int'(bus.done), 1);

        // maximum length, no wrap in the last-beat compare
        @(negedge clk);
        bus.start = 1'b1; bus.k_len = 8'd255; bus.in_valid = 1'b1;
        enables  = 0;
        last_idx = -1;
        done_at  = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.pe_enable) begin
                enables++;
                last_idx = int'(bus.k_idx);
            end
            if (bus.done) begin
                done_at = c;
                break;
            end
        end
        chk("max done latency", done_at, 258);
        chk("max beat count", enables, 255);
        chk("max last k_idx", last_idx, 254);
        @(negedge clk);
        #1 chk("max done pulse width", int'(bus.done), 0);
        chk("max back to idle", int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/outer_product_ctrl.md
OUTER_PRODUCT_CTRL -- requirements
Module: outer_product_ctrl

Interface
REQ-001 SHALL have parameter K_WIDTH, default 8: width of the inner-dimension length and the beat index.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  command strobe, sampled only in IDLE.
REQ-005 SHALL have port k_len  input  K_WIDTH  number of operand beats to accumulate, latched with start.
REQ-006 SHALL have port abort  input  1  cancels the current job.
REQ-007 SHALL have port in_valid  input  1  broadcast operand pair (a, b) present on the PE array inputs.
REQ-008 SHALL have port in_ready  output  1  controller accepts an operand beat.
REQ-009 SHALL have port pe_clear  output  1  drives the clear input of every PE.
REQ-010 SHALL have port pe_enable  output  1  drives the enable input of every PE.
REQ-011 SHALL have port k_idx  output  K_WIDTH  index of the current beat, 0..k_len-1.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  single-cycle pulse: PE accumulators hold the final result.

Function
REQ-014 SHALL implement the states IDLE, CLEAR, ACCUM, DRAIN and DONE, one-hot or binary encoded.
REQ-015 IDLE with start=1 and abort=0 SHALL latch k_len and go to CLEAR; start outside IDLE SHALL be ignored.
REQ-016 CLEAR SHALL last 1 cycle with pe_clear=1, then go to ACCUM if the latched k_len>0, else to DRAIN.
REQ-017 In ACCUM, in_ready SHALL be 1 and pe_enable SHALL equal in_valid & in_ready combinationally.
REQ-018 Each accepted beat SHALL increment k_idx; the beat with k_idx = k_len-1 SHALL move the FSM to DRAIN.
REQ-019 DRAIN SHALL last 1 cycle with pe_enable=0, covering the one-cycle PE register latency, then go to DONE.
REQ-020 DONE SHALL assert done for exactly 1 cycle, then return to IDLE.
REQ-021 in_ready, pe_enable and pe_clear SHALL be 0 in IDLE, DRAIN and DONE.
REQ-022 abort=1 in any state SHALL force IDLE on the next edge with no done pulse; abort wins over a simultaneous start.
REQ-023 in_valid=0 in ACCUM SHALL stall the FSM with k_idx held.
REQ-024 Latency from the start edge to done, with no stalls, SHALL be k_len+3 cycles; with k_len=0 it SHALL be 3 cycles.
REQ-025 k_len = 2^K_WIDTH-1 SHALL be supported, and the k_idx compare SHALL NOT wrap.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, k_idx=0, the latched k_len=0, and all outputs to 0.
REQ-027 rst asserted mid-job SHALL drop in_ready, pe_enable and busy immediately, with no done pulse; PE contents are then don't-care.
REQ-028 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-029 With macro OUTER_PRODUCT_CTRL_PERF_EN defined, the block SHALL add output stall_cnt (16 bits), counting ACCUM cycles with in_valid=0.
REQ-030 stall_cnt SHALL saturate at 16'hFFFF, clear on accepted start and on rst, and hold its value in IDLE.
REQ-031 Without the macro, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario: start with k_len=4 and in_valid held high -> pe_clear at cycle 1, pe_enable at cycles 2-5 with k_idx 0..3, done at cycle 7.
REQ-033 Scenario: k_len=3 with in_valid low for 2 cycles after the first beat -> k_idx holds at 1, done at cycle 8; stall_cnt=2 when the macro is defined.
REQ-034 Scenario: k_len=0 -> a single pe_clear, no pe_enable, done at cycle 3.
REQ-035 Scenario: abort asserted at the second ACCUM beat -> IDLE on the next cycle, done never asserted, busy=0; a following start with k_len=2 completes normally.
REQ-036 Scenario: rst pulsed asynchronously mid-ACCUM -> all outputs 0 before the next clk edge; start accepted on the first edge after release.
REQ-037 Scenario: start pulsed during ACCUM with a different k_len -> ignored, and the original job completes with its own length.
